wb_intercon: RTL and testbench

Parametrised Wishbone classic interconnect for the SoC bus: connects NUM_MASTERS masters to NUM_SLAVES slaves. It arbitrates round-robin between masters and decodes one-hot address bits to select a slave. It detects decode errors and hung slaves, answering the master with `err` instead of stalling. It replaces the fixed single-master decode/ack-OR/data-mux glue in the top level and frees bus capacity for a second master (e.g. DMA).

---
 rtl/wb_intercon.sv | 157 +++++++++++++++
 tb/tb_wb_intercon.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_intercon.sv
// Round-robin Wishbone classic interconnect with one-hot decode: 1-cycle grant, zero-latency ack/data path.
// Masters are never stalled forever: bad decodes and silent slaves answer with err; losers wait holding cyc.
module wb_intercon #(
    parameter int          NUM_MASTERS = 2,
    parameter int          NUM_SLAVES  = 6,
    parameter int          SEL_LSB     = 26,
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_MASTERS-1:0]   m_cyc_i,
    input  logic [NUM_MASTERS-1:0]   m_stb_i,
    input  logic [NUM_MASTERS-1:0]   m_we_i,
    input  logic [4*NUM_MASTERS-1:0] m_sel_i,
    input  logic [32*NUM_MASTERS-1:0] m_adr_i,
    input  logic [32*NUM_MASTERS-1:0] m_dat_i,
    output logic [NUM_MASTERS-1:0]   m_ack_o,
    output logic [NUM_MASTERS-1:0]   m_err_o,
    output logic [31:0]              m_dat_o,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    output logic                     s_we_o,
    output logic [3:0]               s_sel_o,
    output logic [31:0]              s_adr_o,
    output logic [31:0]              s_dat_o,
    input  logic [NUM_SLAVES-1:0]    s_ack_i,
    input  logic [32*NUM_SLAVES-1:0] s_dat_i
);
    localparam int MW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;
    localparam logic           WD_EN   = (TIMEOUT != 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         r_state, w_state_nxt;
    logic [MW-1:0]  r_grant, w_grant_nxt;
    logic [MW-1:0]  r_rr_ptr, w_rr_ptr_nxt;
    logic [WDW-1:0] r_wdog, w_wdog_nxt;
    logic           r_err, w_err_nxt;

    logic                  w_busy;
    logic                  w_cyc;
    logic                  w_stb;
    logic                  w_we;
    logic [3:0]            w_sel;
    logic [31:0]           w_adr;
    logic [31:0]           w_dat;
    logic [NUM_SLAVES-1:0] w_dec;
    logic                  w_dec_ok;
    logic [SW-1:0]         w_sidx;
    logic                  w_strobe;
    logic                  w_ack;
    logic                  w_fire;
    logic                  w_found;
    logic [MW:0]           w_sum;

    assign w_busy   = (r_state == BUSY);
    assign w_cyc    = m_cyc_i[r_grant];
    assign w_stb    = m_stb_i[r_grant];
    assign w_we     = m_we_i[r_grant];
    assign w_sel    = m_sel_i[4*int'(r_grant) +: 4];
    assign w_adr    = m_adr_i[32*int'(r_grant) +: 32];
    assign w_dat    = m_dat_i[32*int'(r_grant) +: 32];
    assign w_dec    = w_adr[SEL_LSB +: NUM_SLAVES];
    assign w_dec_ok = $onehot(w_dec);

    always_comb begin
        w_sidx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_dec[i]) w_sidx = SW'(i);
        end
    end

    // The slave is hidden during the err cycle so a late ack cannot collide with err.
    assign w_strobe = w_busy & w_cyc & w_stb & w_dec_ok & ~r_err;
    assign w_ack    = w_strobe & s_ack_i[w_sidx];
    assign w_fire   = w_busy & w_cyc & w_stb & ~r_err &
                      (~w_dec_ok | (WD_EN & ~w_ack & (r_wdog == WD_LAST)));

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        w_wdog_nxt   = '0;
        w_err_nxt    = w_fire;
        w_found      = 1'b0;
        w_sum        = '0;
        case (r_state)
            IDLE: begin
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    w_sum = {1'b0, r_rr_ptr} + (MW+1)'(i);
                    if (w_sum >= (MW+1)'(NUM_MASTERS)) w_sum = w_sum - (MW+1)'(NUM_MASTERS);
                    if (!w_found && m_cyc_i[w_sum[MW-1:0]]) begin
                        w_found     = 1'b1;
                        w_grant_nxt = w_sum[MW-1:0];
                        w_state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (w_strobe && !w_ack && !w_fire) w_wdog_nxt = r_wdog + 1'b1;
                if (!w_cyc) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = (r_grant == MW'(NUM_MASTERS - 1)) ? '0 : r_grant + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_wdog   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_wdog   <= w_wdog_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_dat_o = '0;
        if (w_busy) begin
            s_we_o  = w_we;
            s_sel_o = w_sel;
            s_adr_o = w_adr;
            s_dat_o = w_dat;
            if (w_strobe) begin
                s_cyc_o          = w_dec;
                s_stb_o          = w_dec;
                m_ack_o[r_grant] = w_ack;
                m_dat_o          = s_dat_i[32*int'(w_sidx) +: 32];
            end
            if (r_err) begin
                m_err_o[r_grant] = 1'b1;
                m_dat_o          = ERR_DATA;
            end
        end
    end
endmodule

// File: tb/tb_wb_intercon.sv
// Directed bench for wb_intercon: 2 masters, 6 slaves, watchdog shortened to 8 cycles.
module tb_wb_intercon;
    localparam int NM = 2;
    localparam int NS = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
    logic [4*NM-1:0]   m_sel_i;
    logic [32*NM-1:0]  m_adr_i, m_dat_i;
    logic [NM-1:0]     m_ack_o, m_err_o;
    logic [31:0]       m_dat_o;
    logic [NS-1:0]     s_cyc_o, s_stb_o, s_ack_i;
    logic              s_we_o;
    logic [3:0]        s_sel_o;
    logic [31:0]       s_adr_o, s_dat_o;
    logic [32*NS-1:0]  s_dat_i;

    int n_checks = 0;
    int n_fail   = 0;

    wb_intercon #(
        .NUM_MASTERS(NM),
        .NUM_SLAVES (NS),
        .SEL_LSB    (26),
        .TIMEOUT    (8),
        .ERR_DATA   (32'hDEADBEEF)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .m_cyc_i(m_cyc_i),
        .m_stb_i(m_stb_i),
        .m_we_i (m_we_i),
        .m_sel_i(m_sel_i),
        .m_adr_i(m_adr_i),
        .m_dat_i(m_dat_i),
        .m_ack_o(m_ack_o),
        .m_err_o(m_err_o),
        .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o),
        .s_stb_o(s_stb_o),
        .s_we_o (s_we_o),
        .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i),
        .s_dat_i(s_dat_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_m(input int k, input logic on, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
        m_cyc_i[k]          = on;
        m_stb_i[k]          = on;
        m_we_i[k]           = we;
        m_sel_i[4*k +: 4]   = on ? 4'hF : 4'h0;
        m_adr_i[32*k +: 32] = adr;
        m_dat_i[32*k +: 32] = dat;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = '0;
        m_sel_i = '0;
        m_adr_i = '0;
        m_dat_i = '0;
        s_ack_i = '0;
        for (int i = 0; i < NS; i++) s_dat_i[32*i +: 32] = 32'h5000_0000 + i;
        s_dat_i[32 +: 32] = 32'h12345678;
        tick();
        tick();
        mid();
        n_checks++;
        if ({s_cyc_o, s_stb_o} !== 12'h000) begin
            n_fail++; $display("FAIL reset_slave_strobes: got %b expected 0", {s_cyc_o, s_stb_o});
        end
        n_checks++;
        if ({m_ack_o, m_err_o} !== 4'h0) begin
            n_fail++; $display("FAIL reset_ack_err: got %b expected 0", {m_ack_o, m_err_o});
        end
        n_checks++;
        if ({s_we_o, s_sel_o, s_adr_o, s_dat_o, m_dat_o} !== '0) begin
            n_fail++; $display("FAIL reset_buses: adr %h dat %h mdat %h expected 0", s_adr_o, s_dat_o, m_dat_o);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        tick();
        set_m(0, 1'b1, 1'b1, 32'h10000004, 32'hA5A50001);
        mid();
        n_checks++;
        if (s_cyc_o !== 6'b000000) begin
            n_fail++; $display("FAIL write_arb_latency: s_cyc got %b expected 000000", s_cyc_o);
        end
        tick();
        mid();
        n_checks++;
        if (s_cyc_o !== 6'b000100 || s_stb_o !== 6'b000100) begin
            n_fail++; $display("FAIL write_select: cyc %b stb %b expected 000100", s_cyc_o, s_stb_o);
        end
        n_checks++;
        if (s_adr_o !== 32'h10000004 || s_dat_o !== 32'hA5A50001 || s_we_o !== 1'b1 || s_sel_o !== 4'hF) begin
            n_fail++; $display("FAIL write_bus: adr %h dat %h we %b sel %h expected 10000004 a5a50001 1 f",
                               s_adr_o, s_dat_o, s_we_o, s_sel_o);
        end
        n_checks++;
        if (m_ack_o !== 2'b00) begin
            n_fail++; $display("FAIL write_early_ack: got %b expected 00", m_ack_o);
        end
        tick();
        tick();
        s_ack_i = 6'b000100;
        mid();
        n_checks++;
        if (m_ack_o !== 2'b01 || m_err_o !== 2'b00) begin
            n_fail++; $display("FAIL write_ack: ack %b err %b expected 01 00", m_ack_o, m_err_o);
        end
        tick();
        s_ack_i = '0;
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_read();
        tick();
        set_m(0, 1'b1, 1'b0, 32'h08000000, 32'h0);
        tick();
        s_ack_i = 6'b000100;
        mid();
        n_checks++;
        if (m_ack_o !== 2'b00 || s_cyc_o !== 6'b000010) begin
            n_fail++; $display("FAIL read_foreign_ack: ack %b cyc %b expected 00 000010", m_ack_o, s_cyc_o);
        end
        tick();
        s_ack_i = 6'b000010;
        mid();
        n_checks++;
        if (m_ack_o !== 2'b01 || m_dat_o !== 32'h12345678) begin
            n_fail++; $display("FAIL read_data: ack %b dat %h expected 01 12345678", m_ack_o, m_dat_o);
        end
        tick();
        s_ack_i = '0;
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_decode_err();
        tick();
        s_ack_i = '1;
        set_m(0, 1'b1, 1'b0, 32'h30000000, 32'h0);
        tick();
        mid();
        n_checks++;
        if (s_stb_o !== 6'b000000 || m_err_o !== 2'b00 || m_ack_o !== 2'b00) begin
            n_fail++; $display("FAIL dec2_first: stb %b err %b ack %b expected 0 00 00", s_stb_o, m_err_o, m_ack_o);
        end
        tick();
        mid();
        n_checks++;
        if (m_err_o !== 2'b01 || m_dat_o !== 32'hDEADBEEF || m_ack_o !== 2'b00 || s_stb_o !== 6'b0) begin
            n_fail++; $display("FAIL dec2_err: err %b dat %h ack %b stb %b expected 01 deadbeef 00 0",
                               m_err_o, m_dat_o, m_ack_o, s_stb_o);
        end
        tick();
        set_m(0, 1'b1, 1'b0, 32'h00000000, 32'h0);
        mid();
        n_checks++;
        if (m_err_o !== 2'b00) begin
            n_fail++; $display("FAIL dec_err_width: err %b expected 00", m_err_o);
        end
        tick();
        mid();
        n_checks++;
        if (m_err_o !== 2'b01 || m_dat_o !== 32'hDEADBEEF || s_stb_o !== 6'b0) begin
            n_fail++; $display("FAIL dec0_err: err %b dat %h stb %b expected 01 deadbeef 0", m_err_o, m_dat_o, s_stb_o);
        end
        tick();
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        mid();
        n_checks++;
        if (m_err_o !== 2'b00) begin
            n_fail++; $display("FAIL dec_err_clear: err %b expected 00", m_err_o);
        end
        s_ack_i = '0;
        tick();
    endtask

    task automatic test_timeout();
        tick();
        set_m(0, 1'b1, 1'b0, 32'h04000000, 32'h0);
        for (int c = 1; c <= 18; c++) begin
            tick();
            mid();
            n_checks++;
            if (m_err_o !== ((c == 9 || c == 18) ? 2'b01 : 2'b00) ||
                s_stb_o !== ((c == 9 || c == 18) ? 6'b000000 : 6'b000001)) begin
                n_fail++; $display("FAIL timeout_cycle%0d: err %b stb %b", c, m_err_o, s_stb_o);
            end
        end
        tick();
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        set_m(0, 1'b1, 1'b0, 32'h04000000, 32'h0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 8) s_ack_i = 6'b000001;
            mid();
            n_checks++;
            if (m_ack_o !== ((c == 8) ? 2'b01 : 2'b00) || m_err_o !== 2'b00) begin
                n_fail++; $display("FAIL late_ack_cycle%0d: ack %b err %b", c, m_ack_o, m_err_o);
            end
        end
        tick();
        s_ack_i = '0;
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        mid();
        n_checks++;
        if (m_err_o !== 2'b00) begin
            n_fail++; $display("FAIL late_ack_no_err: err %b expected 00", m_err_o);
        end
        tick();
    endtask

    task automatic test_round_robin();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        s_ack_i = '1;
        set_m(0, 1'b1, 1'b0, 32'h08000010, 32'h0);
        set_m(1, 1'b1, 1'b1, 32'h20000020, 32'h11);
        for (int r = 0; r < 4; r++) begin
            int g;
            g = r % 2;
            mid();
            n_checks++;
            if (s_cyc_o !== 6'b000000 || m_ack_o !== 2'b00) begin
                n_fail++; $display("FAIL rr_gap%0d: cyc %b ack %b expected 0 00", r, s_cyc_o, m_ack_o);
            end
            tick();
            mid();
            n_checks++;
            if (m_ack_o !== ((g == 0) ? 2'b01 : 2'b10) ||
                s_cyc_o !== ((g == 0) ? 6'b000010 : 6'b001000) ||
                s_adr_o !== ((g == 0) ? 32'h08000010 : 32'h20000020)) begin
                n_fail++; $display("FAIL rr_grant%0d: ack %b cyc %b adr %h expected master %0d", r, m_ack_o, s_cyc_o, s_adr_o, g);
            end
            tick();
            set_m(g, 1'b0, 1'b0, 32'h0, 32'h0);
            mid();
            n_checks++;
            if (m_ack_o !== 2'b00) begin
                n_fail++; $display("FAIL rr_release%0d: ack %b expected 00", r, m_ack_o);
            end
            tick();
            if (r < 3) begin
                if (g == 0) set_m(0, 1'b1, 1'b0, 32'h08000010, 32'h0);
                else        set_m(1, 1'b1, 1'b1, 32'h20000020, 32'h11);
            end
        end
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
        s_ack_i = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        s_ack_i = '1;
        set_m(0, 1'b1, 1'b0, 32'h08000010, 32'h0);
        tick();
        tick();
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        s_ack_i = '0;
        set_m(1, 1'b1, 1'b1, 32'h20000040, 32'h77);
        tick();
        mid();
        n_checks++;
        if (s_cyc_o !== 6'b001000) begin
            n_fail++; $display("FAIL rst_mid_setup: cyc %b expected 001000", s_cyc_o);
        end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        s_ack_i = '1;
        set_m(0, 1'b1, 1'b0, 32'h08000010, 32'h0);
        mid();
        n_checks++;
        if (s_cyc_o !== 6'b0 || s_stb_o !== 6'b0 || m_ack_o !== 2'b00 || m_err_o !== 2'b00 ||
            m_dat_o !== 32'h0 || s_adr_o !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_outputs: cyc %b stb %b ack %b err %b adr %h expected all 0",
                               s_cyc_o, s_stb_o, m_ack_o, m_err_o, s_adr_o);
        end
        tick();
        mid();
        n_checks++;
        if (m_ack_o !== 2'b01 || s_cyc_o !== 6'b000010) begin
            n_fail++; $display("FAIL rst_mid_rr: ack %b cyc %b expected 01 000010", m_ack_o, s_cyc_o);
        end
        tick();
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
        s_ack_i = '0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_decode_err();
        test_timeout();
        test_round_robin();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
